voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of polyphonic voices (legal range 2..16).
REQ-002 Parameter CHANNEL_MASK, default 16'hFFFF, bit n set = MIDI channel n accepted.
REQ-003 Port clk32  in  1  system clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Port note_pressed  in  1  single-cycle note-on strobe from the MIDI controller.
REQ-006 Port note_released  in  1  single-cycle note-off strobe.
REQ-007 Port note  in  7  MIDI note number, valid with either strobe.
REQ-008 Port velocity  in  7  MIDI velocity, valid with either strobe.
REQ-009 Port channel  in  4  MIDI channel, valid with either strobe.
REQ-010 Port all_off  in  1  synchronous all-notes-off request.
REQ-011 Port gate  out  NUM_VOICES  per-voice active flag.
REQ-012 Port voice_note  out  7*NUM_VOICES  per-voice note; voice i occupies bits [7i+6:7i].
REQ-013 Port voice_vel  out  7*NUM_VOICES  per-voice velocity, same packing.
REQ-014 Port trig  out  NUM_VOICES  one-cycle strobe on voice (re)start, for envelope restart.
REQ-015 Port active_cnt  out  5  number of voices with gate=1.
REQ-016 Port drop  out  1  one-cycle strobe: a note-on was discarded.

Function
REQ-017 Events whose channel bit is clear in CHANNEL_MASK SHALL be ignored: no state change, no drop.
REQ-018 Every output SHALL change exactly one clk32 cycle after the accepted strobe (registered, latency 1).
REQ-019 A note-on with velocity 0 SHALL be treated as a note-off.
REQ-020 Note-on matching an active voice (same note and channel) SHALL retrigger that voice: update vel, pulse trig, reset age to 0.
REQ-021 Otherwise a note-on SHALL allocate the lowest-index voice with gate=0: set gate, note, vel, stored channel; pulse trig.
REQ-022 Each voice SHALL hold an age counter (4 bits); on allocation or retrigger the target age becomes 0 and every other active voice's age increments, saturating at NUM_VOICES-1.
REQ-023 Note-off SHALL clear gate of every active voice matching note and channel; note/vel outputs keep last value; no match = no effect.
REQ-024 all_off SHALL clear all gates and ages next cycle and take priority over both strobes in the same cycle.
REQ-025 note_pressed and note_released asserted together: release processed, press discarded with drop=1.
REQ-026 active_cnt SHALL equal the popcount of gate, updated in the same cycle as gate.
REQ-027 trig and drop SHALL be 0 in every cycle without a corresponding event.

Reset
REQ-028 While rst=1: gate=0, trig=0, drop=0, active_cnt=0, voice_note=0, voice_vel=0, all ages 0, stored channels 0.
REQ-029 Reset SHALL take effect asynchronously, including mid-event; the first strobe after deassertion is processed normally.

Configuration
REQ-030 Macro VOICE_STEAL_EN defined: note-on with all voices active SHALL steal the voice with the highest age (lowest index on ties): overwrite note/vel/channel, pulse trig, drop=0.
REQ-031 Macro VOICE_STEAL_EN undefined: note-on with all voices active SHALL be discarded with drop=1; no voice state changes.

Verification
REQ-032 NUM_VOICES=4; note-on 60,62,64 vel 100 ch0 -> gate=0111, voices 0..2 notes 60/62/64, trig pulses 001,010,100, active_cnt=3.
REQ-033 After REQ-032: note-off 62 ch0 then note-on 67 -> gate 0111 with voice1 note 67; then note-on 60 vel 0 -> voice0 gate cleared.
REQ-034 Five note-ons 60..64 on 4 voices -> VOICE_STEAL_EN: voice0 becomes 64, drop=0; undefined: drop=1, voices unchanged.
REQ-035 Note-on 60 ch0 twice (vel 50 then 90) -> one voice, vel 90, trig pulsed twice, active_cnt=1.
REQ-036 CHANNEL_MASK=16'h0001: note-on ch3 -> no change, drop=0; all_off with simultaneous note_pressed -> gate=0, active_cnt=0.
REQ-037 rst asserted mid-sequence with 3 voices active -> all outputs 0 immediately, before next clk32 edge.

Source files
------------

// File: rtl/voice_allocator.sv
// Polyphonic MIDI voice allocator: maps note-on/off events onto NUM_VOICES voice slots.
// Optional macro VOICE_STEAL_EN: when all voices are busy, steal the oldest one instead of dropping.
module voice_allocator #(
   parameter int          NUM_VOICES   = 4,
   parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
   input  logic                    clk32,
   input  logic                    rst,
   input  logic                    note_pressed,
   input  logic                    note_released,
   input  logic [6:0]              note,
   input  logic [6:0]              velocity,
   input  logic [3:0]              channel,
   input  logic                    all_off,
   output logic [NUM_VOICES-1:0]   gate,
   output logic [7*NUM_VOICES-1:0] voice_note,
   output logic [7*NUM_VOICES-1:0] voice_vel,
   output logic [NUM_VOICES-1:0]   trig,
   output logic [4:0]              active_cnt,
   output logic                    drop
);

   localparam logic [3:0] AGE_MAX = 4'(NUM_VOICES - 1);
`ifdef VOICE_STEAL_EN
   localparam bit STEAL = 1'b1;
`else
   localparam bit STEAL = 1'b0;
`endif

   logic [NUM_VOICES-1:0] r_gate, r_trig;
   logic [6:0]            r_note [NUM_VOICES];
   logic [6:0]            r_vel  [NUM_VOICES];
   logic [3:0]            r_chan [NUM_VOICES];
   logic [3:0]            r_age  [NUM_VOICES];
   logic [4:0]            r_cnt;
   logic                  r_drop;

   logic                  w_ch_ok, w_on, w_off, w_both;
   logic                  w_hit, w_free, w_alloc, w_drop;
   int                    w_hit_idx, w_free_idx, w_old_idx, w_tgt;
   logic [3:0]            w_old_age;

   logic [NUM_VOICES-1:0] w_gate_n, w_trig_n;
   logic [6:0]            w_note_n [NUM_VOICES];
   logic [6:0]            w_vel_n  [NUM_VOICES];
   logic [3:0]            w_chan_n [NUM_VOICES];
   logic [3:0]            w_age_n  [NUM_VOICES];
   logic [4:0]            w_cnt_n;

   // Event decode and target-voice search
   always_comb begin
      w_ch_ok    = CHANNEL_MASK[channel];
      w_both     = w_ch_ok & note_pressed & note_released;
      w_off      = w_ch_ok & (note_released | (note_pressed & (velocity == 7'd0)));
      w_on       = w_ch_ok & note_pressed & ~note_released & (velocity != 7'd0);
      w_hit      = 1'b0;
      w_hit_idx  = 0;
      w_free     = 1'b0;
      w_free_idx = 0;
      w_old_idx  = 0;
      w_old_age  = 4'd0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (r_gate[i] && r_note[i] == note && r_chan[i] == channel && !w_hit) begin
            w_hit     = 1'b1;
            w_hit_idx = i;
         end
         if (!r_gate[i] && !w_free) begin
            w_free     = 1'b1;
            w_free_idx = i;
         end
         // Strict compare keeps the lowest index on equal ages
         if (r_age[i] > w_old_age) begin
            w_old_age = r_age[i];
            w_old_idx = i;
         end
      end
      w_alloc = 1'b0;
      w_tgt   = 0;
      w_drop  = 1'b0;
      if (!all_off) begin
         w_drop = w_both;
         if (w_on) begin
            if (w_hit) begin
               w_alloc = 1'b1;
               w_tgt   = w_hit_idx;
            end else if (w_free) begin
               w_alloc = 1'b1;
               w_tgt   = w_free_idx;
            end else if (STEAL) begin
               w_alloc = 1'b1;
               w_tgt   = w_old_idx;
            end else begin
               w_drop  = 1'b1;
            end
         end
      end
   end

   // Next voice state
   always_comb begin
      w_gate_n = r_gate;
      w_trig_n = '0;
      w_note_n = r_note;
      w_vel_n  = r_vel;
      w_chan_n = r_chan;
      w_age_n  = r_age;
      if (all_off) begin
         w_gate_n = '0;
         for (int i = 0; i < NUM_VOICES; i++) w_age_n[i] = 4'd0;
      end else if (w_off) begin
         for (int i = 0; i < NUM_VOICES; i++)
            if (r_gate[i] && r_note[i] == note && r_chan[i] == channel) w_gate_n[i] = 1'b0;
      end else if (w_alloc) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (i == w_tgt) begin
               w_gate_n[i] = 1'b1;
               w_trig_n[i] = 1'b1;
               w_note_n[i] = note;
               w_vel_n[i]  = velocity;
               w_chan_n[i] = channel;
               w_age_n[i]  = 4'd0;
            end else if (r_gate[i] && r_age[i] < AGE_MAX) begin
               w_age_n[i]  = r_age[i] + 4'd1;
            end
         end
      end
      w_cnt_n = 5'd0;
      for (int i = 0; i < NUM_VOICES; i++) w_cnt_n = w_cnt_n + 5'(w_gate_n[i]);
   end

   always_ff @(posedge clk32 or posedge rst) begin
      if (rst) begin
         r_gate <= '0;
         r_trig <= '0;
         r_cnt  <= 5'd0;
         r_drop <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_note[i] <= 7'd0;
            r_vel[i]  <= 7'd0;
            r_chan[i] <= 4'd0;
            r_age[i]  <= 4'd0;
         end
      end else begin
         r_gate <= w_gate_n;
         r_trig <= w_trig_n;
         r_cnt  <= w_cnt_n;
         r_drop <= w_drop;
         r_note <= w_note_n;
         r_vel  <= w_vel_n;
         r_chan <= w_chan_n;
         r_age  <= w_age_n;
      end
   end

   assign gate       = r_gate;
   assign trig       = r_trig;
   assign active_cnt = r_cnt;
   assign drop       = r_drop;

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
      assign voice_note[7*g +: 7] = r_note[g];
      assign voice_vel[7*g +: 7]  = r_vel[g];
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (4 voices, only MIDI channel 0 accepted).
module tb_voice_allocator;

   localparam int NV = 4;

   logic          clk32 = 1'b0;
   logic          rst;
   logic          note_pressed, note_released, all_off;
   logic [6:0]    note, velocity;
   logic [3:0]    channel;
   logic [NV-1:0] gate, trig;
   logic [7*NV-1:0] voice_note, voice_vel;
   logic [4:0]    active_cnt;
   logic          drop;

   int checks = 0;
   int errors = 0;

   voice_allocator #(.NUM_VOICES(NV), .CHANNEL_MASK(16'h0001)) dut (
      .clk32(clk32), .rst(rst),
      .note_pressed(note_pressed), .note_released(note_released),
      .note(note), .velocity(velocity), .channel(channel), .all_off(all_off),
      .gate(gate), .voice_note(voice_note), .voice_vel(voice_vel),
      .trig(trig), .active_cnt(active_cnt), .drop(drop)
   );

   always #5 clk32 = ~clk32;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One event cycle: drive at negedge, strobes cleared just after the capturing edge
   task automatic ev(input logic p, input logic r, input logic [6:0] n, input logic [6:0] v,
                     input logic [3:0] ch, input logic ao);
      @(negedge clk32);
      note_pressed = p; note_released = r; note = n; velocity = v; channel = ch; all_off = ao;
      @(posedge clk32);
      #1;
      note_pressed = 1'b0; note_released = 1'b0; all_off = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      note_pressed = 1'b0; note_released = 1'b0; all_off = 1'b0;
      note = 7'd0; velocity = 7'd0; channel = 4'd0;
      repeat (2) @(posedge clk32);
      #1;
      chk("rst_gate", 32'(gate), 32'h0);
      chk("rst_cnt", 32'(active_cnt), 32'h0);
      chk("rst_trig", 32'(trig), 32'h0);
      chk("rst_drop", 32'(drop), 32'h0);
      chk("rst_note", 32'(voice_note), 32'h0);
      chk("rst_vel", 32'(voice_vel), 32'h0);
      @(negedge clk32);
      rst = 1'b0;

      ev(1, 0, 7'd60, 7'd100, 4'd0, 0);
      chk("on60_gate", 32'(gate), 32'b0001);
      chk("on60_trig", 32'(trig), 32'b0001);
      chk("on60_cnt", 32'(active_cnt), 32'd1);
      ev(1, 0, 7'd62, 7'd100, 4'd0, 0);
      chk("on62_gate", 32'(gate), 32'b0011);
      chk("on62_trig", 32'(trig), 32'b0010);
      ev(1, 0, 7'd64, 7'd100, 4'd0, 0);
      chk("on64_gate", 32'(gate), 32'b0111);
      chk("on64_trig", 32'(trig), 32'b0100);
      chk("on64_cnt", 32'(active_cnt), 32'd3);
      chk("on64_notes", 32'(voice_note), 32'({7'd0, 7'd64, 7'd62, 7'd60}));
      chk("on64_vels", 32'(voice_vel), 32'({7'd0, 7'd100, 7'd100, 7'd100}));
      ev(0, 0, 7'd0, 7'd0, 4'd0, 0);
      chk("idle_trig", 32'(trig), 32'h0);
      chk("idle_drop", 32'(drop), 32'h0);

      ev(0, 1, 7'd62, 7'd0, 4'd0, 0);
      chk("off62_gate", 32'(gate), 32'b0101);
      chk("off62_cnt", 32'(active_cnt), 32'd2);
      chk("off62_keepnote", 32'(voice_note[13:7]), 32'd62);
      ev(1, 0, 7'd67, 7'd100, 4'd0, 0);
      chk("on67_gate", 32'(gate), 32'b0111);
      chk("on67_trig", 32'(trig), 32'b0010);
      chk("on67_note", 32'(voice_note[13:7]), 32'd67);
      ev(1, 0, 7'd60, 7'd0, 4'd0, 0);
      chk("vel0_gate", 32'(gate), 32'b0110);
      chk("vel0_trig", 32'(trig), 32'h0);
      chk("vel0_cnt", 32'(active_cnt), 32'd2);

      ev(1, 0, 7'd70, 7'd100, 4'd0, 1);
      chk("alloff_gate", 32'(gate), 32'h0);
      chk("alloff_cnt", 32'(active_cnt), 32'd0);
      chk("alloff_trig", 32'(trig), 32'h0);
      chk("alloff_drop", 32'(drop), 32'h0);

      ev(1, 0, 7'd60, 7'd100, 4'd0, 0);
      ev(1, 0, 7'd61, 7'd100, 4'd0, 0);
      ev(1, 0, 7'd62, 7'd100, 4'd0, 0);
      ev(1, 0, 7'd63, 7'd100, 4'd0, 0);
      chk("full_gate", 32'(gate), 32'b1111);
      chk("full_cnt", 32'(active_cnt), 32'd4);
      ev(1, 0, 7'd64, 7'd100, 4'd0, 0);
      chk("over_gate", 32'(gate), 32'b1111);
`ifdef VOICE_STEAL_EN
      chk("steal_drop", 32'(drop), 32'h0);
      chk("steal_trig", 32'(trig), 32'b0001);
      chk("steal_notes", 32'(voice_note), 32'({7'd63, 7'd62, 7'd61, 7'd64}));
`else
      chk("over_drop", 32'(drop), 32'h1);
      chk("over_trig", 32'(trig), 32'h0);
      chk("over_notes", 32'(voice_note), 32'({7'd63, 7'd62, 7'd61, 7'd60}));
`endif
      ev(0, 0, 7'd0, 7'd0, 4'd0, 0);
      chk("drop_clears", 32'(drop), 32'h0);

      ev(1, 0, 7'd70, 7'd100, 4'd3, 0);
      chk("mask_drop", 32'(drop), 32'h0);
      chk("mask_gate", 32'(gate), 32'b1111);
      chk("mask_trig", 32'(trig), 32'h0);

      ev(1, 1, 7'd61, 7'd100, 4'd0, 0);
      chk("both_gate", 32'(gate), 32'b1101);
      chk("both_drop", 32'(drop), 32'h1);
      chk("both_cnt", 32'(active_cnt), 32'd3);

      ev(0, 0, 7'd0, 7'd0, 4'd0, 1);
      chk("alloff2_gate", 32'(gate), 32'h0);
      ev(1, 0, 7'd60, 7'd50, 4'd0, 0);
      chk("rt1_trig", 32'(trig), 32'b0001);
      chk("rt1_vel", 32'(voice_vel[6:0]), 32'd50);
      ev(1, 0, 7'd60, 7'd90, 4'd0, 0);
      chk("rt2_gate", 32'(gate), 32'b0001);
      chk("rt2_trig", 32'(trig), 32'b0001);
      chk("rt2_vel", 32'(voice_vel[6:0]), 32'd90);
      chk("rt2_cnt", 32'(active_cnt), 32'd1);

      ev(1, 0, 7'd62, 7'd100, 4'd0, 0);
      ev(1, 0, 7'd64, 7'd100, 4'd0, 0);
      chk("pre_rst_gate", 32'(gate), 32'b0111);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_gate", 32'(gate), 32'h0);
      chk("arst_cnt", 32'(active_cnt), 32'd0);
      chk("arst_note", 32'(voice_note), 32'h0);
      chk("arst_vel", 32'(voice_vel), 32'h0);
      chk("arst_trig", 32'(trig), 32'h0);
      @(negedge clk32);
      rst = 1'b0;
      ev(1, 0, 7'd65, 7'd80, 4'd0, 0);
      chk("post_gate", 32'(gate), 32'b0001);
      chk("post_note", 32'(voice_note), 32'd65);
      chk("post_trig", 32'(trig), 32'b0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
